// File: rtl/dif_stage_feeder_pkg.sv
// Shared definitions for the DIF FFT stage: component widths, the {real, imag}
// packing order used by the feeder and the butterfly, the feeder state type,
// and the elaboration-time twiddle helpers used to build the twiddle table.
package dif_stage_feeder_pkg;

    localparam int DATA_WIDTH_DEF   = 32;  // bits per real/imag operand component
    localparam int FACTOR_WIDTH_DEF = 16;  // bits per real/imag twiddle component
    localparam int FRAC_BITS_DEF    = 14;  // twiddle fixed point: 1.0 = 2**FRAC_BITS
    localparam int N_DEF            = 16;  // points per frame

    // Complex words are packed {real, imag}: real in the upper half, imag in
    // the lower half, both two's complement. The butterfly unpacks the same way.
    localparam bit REAL_IS_UPPER = 1'b1;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ALIGN = 2'd1,
        ISSUE = 2'd2
    } feeder_state_e;

    localparam real PI = 3.14159265358979323846;

    // Round half away from zero.
    function automatic int round_real(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        else          return -$rtoi(-x + 0.5);
    endfunction

    // Real part of W_n^k = exp(-j*2*pi*k/n), scaled by 2**frac.
    function automatic int twiddle_re(input int k, input int n, input int frac);
        real scale;
        scale = $itor(1 << frac);
        return round_real(scale * $cos(2.0 * PI * $itor(k) / $itor(n)));
    endfunction

    // Imag part of W_n^k, scaled by 2**frac.
    function automatic int twiddle_im(input int k, input int n, input int frac);
        real scale;
        scale = $itor(1 << frac);
        return round_real(-scale * $sin(2.0 * PI * $itor(k) / $itor(n)));
    endfunction

endpackage

// File: rtl/dif_stage_feeder_if.sv
// Bus between the sample source, the DIF stage feeder and the butterfly.
//   in_valid/in_ready/in_data : sample stream into the feeder
//   out_x0/out_x1/out_w        : butterfly operand pair and twiddle
//   out_valid/out_phase/out_last : pair qualifiers
// master: the side that sources samples and consumes pairs.
// slave : the feeder itself.
interface dif_stage_feeder_if
    import dif_stage_feeder_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int FACTOR_WIDTH = FACTOR_WIDTH_DEF
);
    logic                      in_valid;
    logic                      in_ready;
    logic [2*DATA_WIDTH-1:0]   in_data;
    logic [2*DATA_WIDTH-1:0]   out_x0;
    logic [2*DATA_WIDTH-1:0]   out_x1;
    logic [2*FACTOR_WIDTH-1:0] out_w;
    logic                      out_valid;
    logic                      out_phase;
    logic                      out_last;

    modport master (
        output in_valid, in_data,
        input  in_ready, out_x0, out_x1, out_w, out_valid, out_phase, out_last
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, out_x0, out_x1, out_w, out_valid, out_phase, out_last
    );
endinterface

// File: rtl/dif_stage_feeder_twiddle_rom.sv
// Twiddle table W_N^k for k = 0..N/2-1, packed {real, imag}, each component
// FACTOR_WIDTH bits with FRAC_BITS fractional bits. Entries are constants
// computed at elaboration; the lookup is purely combinational.
//   k_i : pair index
//   w_o : W_N^k
module twiddle_rom
    import dif_stage_feeder_pkg::*;
#(
    parameter int N            = N_DEF,
    parameter int FACTOR_WIDTH = FACTOR_WIDTH_DEF,
    parameter int FRAC_BITS    = FRAC_BITS_DEF,
    localparam int KW          = $clog2(N / 2)
) (
    input  logic [KW-1:0]             k_i,
    output logic [2*FACTOR_WIDTH-1:0] w_o
);
    logic [2*FACTOR_WIDTH-1:0] tab [N/2];

    for (genvar g = 0; g < N / 2; g++) begin : g_tab
        localparam logic [FACTOR_WIDTH-1:0] W_RE = FACTOR_WIDTH'(twiddle_re(g, N, FRAC_BITS));
        localparam logic [FACTOR_WIDTH-1:0] W_IM = FACTOR_WIDTH'(twiddle_im(g, N, FRAC_BITS));
        assign tab[g] = {W_RE, W_IM};
    end

    // N/2 is a power of two, so every k_i value addresses a real entry.
    assign w_o = tab[k_i];
endmodule

// File: rtl/dif_stage_feeder.sv
// DIF stage feeder: buffers one frame of N complex samples, then presents the
// butterfly pairs (x[k], x[k+N/2], W_N^k) for k = 0..N/2-1, each held for two
// cycles aligned to the butterfly's free-running half-cycle phase.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of dif_stage_feeder_if (sample input, pair output)
// N must be a power of two in 4..64.
module dif_stage_feeder
    import dif_stage_feeder_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int FACTOR_WIDTH = FACTOR_WIDTH_DEF,
    parameter int FRAC_BITS    = FRAC_BITS_DEF,
    parameter int N            = N_DEF
) (
    input  logic              clk,
    input  logic              rst,
    dif_stage_feeder_if.slave bus
);
    localparam int PW   = $clog2(N);
    localparam int KW   = $clog2(N / 2);
    localparam int HALF = N / 2;

    feeder_state_e             state_q, state_d;
    logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [KW-1:0]             k_q, k_d;
    logic                      phase_q;
    logic                      in_ready_q, in_ready_d;
    logic                      out_valid_q, out_valid_d;
    logic                      out_last_q, out_last_d;
    logic [2*DATA_WIDTH-1:0]   out_x0_q, out_x0_d;
    logic [2*DATA_WIDTH-1:0]   out_x1_q, out_x1_d;
    logic [2*FACTOR_WIDTH-1:0] out_w_q, out_w_d;
    logic [2*FACTOR_WIDTH-1:0] w_nxt;
    logic [2*DATA_WIDTH-1:0]   buf_q [N];
    logic                      accept;

    assign accept = bus.in_valid && in_ready_q;

    // Table is indexed by the next pair so the twiddle lands in its output
    // register together with the operands.
    twiddle_rom #(
        .N            (N),
        .FACTOR_WIDTH (FACTOR_WIDTH),
        .FRAC_BITS    (FRAC_BITS)
    ) u_rom (
        .k_i (k_d),
        .w_o (w_nxt)
    );

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        k_d      = k_q;
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    // Wraps back to 0 on the N-th accept, ready for the next frame.
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == PW'(N - 1)) begin
                        // Next cycle's phase is ~phase_q; issue must start on phase 0.
                        state_d = phase_q ? ISSUE : ALIGN;
                    end
                end
            end
            ALIGN: state_d = ISSUE;
            ISSUE: begin
                // A pair advances after its phase-1 cycle.
                if (phase_q) begin
                    if (k_q == KW'(HALF - 1)) begin
                        state_d = FILL;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            default: state_d = FILL;
        endcase

        in_ready_d  = (state_d == FILL);
        out_valid_d = (state_d == ISSUE);
        out_last_d  = out_valid_d && (k_d == KW'(HALF - 1));

        // Operands hold their last values outside ISSUE.
        out_x0_d = out_x0_q;
        out_x1_d = out_x1_q;
        out_w_d  = out_w_q;
        if (out_valid_d) begin
            // k and k+N/2 differ only in the top address bit.
            out_x0_d = buf_q[{1'b0, k_d}];
            out_x1_d = buf_q[{1'b1, k_d}];
            out_w_d  = w_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            wr_ptr_q    <= '0;
            k_q         <= '0;
            phase_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_x0_q    <= '0;
            out_x1_q    <= '0;
            out_w_q     <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            k_q         <= k_d;
            phase_q     <= ~phase_q;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_x0_q    <= out_x0_d;
            out_x1_q    <= out_x1_d;
            out_w_q     <= out_w_d;
        end
    end

    // Frame storage is not reset; a reset restarts wr_ptr so stale words are
    // overwritten before they can be issued.
    always_ff @(posedge clk) begin
        if (accept) buf_q[wr_ptr_q] <= bus.in_data;
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_phase = phase_q;
    assign bus.out_x0    = out_x0_q;
    assign bus.out_x1    = out_x1_q;
    assign bus.out_w     = out_w_q;
endmodule

// File: doc/dif_stage_feeder.md
DIF_STAGE_FEEDER -- requirements
Module: dif_stage_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of each real/imag component.
REQ-002 SHALL have parameter FACTOR_WIDTH, default 16, width of each twiddle component.
REQ-003 SHALL have parameter FRAC_BITS, default 14, twiddle fractional bits (1.0 = 2^FRAC_BITS).
REQ-004 SHALL have parameter N, default 16, points per frame; power of two, 4..64.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-007 SHALL have port in_valid  input  1  sample offered.
REQ-008 SHALL have port in_ready  output  1  feeder accepts a sample this cycle.
REQ-009 SHALL have port in_data  input  2*DATA_WIDTH  sample {real, imag}, signed.
REQ-010 SHALL have port out_x0  output  2*DATA_WIDTH  upper-butterfly operand x[k], {real, imag}.
REQ-011 SHALL have port out_x1  output  2*DATA_WIDTH  lower operand x[k+N/2], {real, imag}.
REQ-012 SHALL have port out_w  output  2*FACTOR_WIDTH  twiddle W_N^k, {real, imag}, signed.
REQ-013 SHALL have port out_valid  output  1  pair on out_x0/out_x1/out_w is live.
REQ-014 SHALL have port out_phase  output  1  free-running half-cycle phase, matches butterfly count.
REQ-015 SHALL have port out_last  output  1  pair is k = N/2-1 of the frame.

Function
REQ-016 SHALL toggle out_phase every cycle; 0 in the first cycle after reset, identical to the downstream butterfly counter under a shared rst.
REQ-017 SHALL implement states FILL, ALIGN, ISSUE.
REQ-018 FILL: in_ready=1; each in_valid&&in_ready writes in_data to buffer[wr_ptr], wr_ptr increments; in_valid gaps pause filling without penalty.
REQ-019 On the N-th accept SHALL leave FILL and deassert in_ready next cycle; go to ISSUE if next-cycle out_phase=0, else ALIGN for one cycle.
REQ-020 ISSUE SHALL present pair k (k=0..N/2-1) stable for exactly two cycles, first with out_phase=0, second with out_phase=1; out_valid=1 in both.
REQ-021 Pair k SHALL be out_x0=buffer[k], out_x1=buffer[k+N/2], out_w=W_N^k; out_last=1 in both cycles of k=N/2-1.
REQ-022 W_N^k SHALL equal round(2^FRAC_BITS*cos(2*pi*k/N)), round(-2^FRAC_BITS*sin(2*pi*k/N)); W_N^0 = {16384, 0} at defaults.
REQ-023 Operands SHALL pass unmodified (no scaling, no rounding); all outputs registered.
REQ-024 After the phase-1 cycle of k=N/2-1 SHALL return to FILL with in_ready=1 next cycle, wr_ptr=0; no overlap of fill and issue.
REQ-025 Outside ISSUE out_valid=0, out_last=0; out_x0/out_x1/out_w hold last values.
REQ-026 Frame throughput SHALL be N fill cycles (minimum) + 0..1 align + N issue cycles.

Reset
REQ-027 rst SHALL force FILL, wr_ptr=0, pair counter 0, out_phase=0, in_ready=1 next cycle, out_valid=0, out_last=0, out_x0=out_x1=out_w=0.
REQ-028 rst mid-fill or mid-issue SHALL discard the partial frame; buffer contents need not be cleared.

Structure
REQ-029 Shared package SHALL hold DATA_WIDTH/FACTOR_WIDTH/FRAC_BITS defaults and the {real,imag} packing order, common with the butterfly.
REQ-030 Twiddle generation SHALL be one sub-module twiddle_rom (combinational/registered table indexed by k, parameterised by N, FACTOR_WIDTH, FRAC_BITS).

Verification
REQ-031 N=8, ramp samples real=1..8, imag=0, in_valid constant -> pairs (1,5),(2,6),(3,7),(4,8), each held 2 cycles, first cycle out_phase=0.
REQ-032 N=8, k=1 -> out_w={11585, -11585}; k=2 -> {0, -16384}; k=3 -> {-11585, -11585}.
REQ-033 Last accept landing so next cycle has out_phase=1 -> exactly one ALIGN cycle with out_valid=0, then pair 0 at out_phase=0.
REQ-034 in_valid gaps (1 on, 2 off) during fill -> identical pair sequence, only delayed; in_ready=0 throughout ISSUE.
REQ-035 rst asserted after 5 of 8 accepts -> out_valid stays 0; next 8 fresh samples form the frame, old 5 absent.
REQ-036 Chained to butterfly: x0={100,0}, x1={20,0}, w={16384,0} -> butterfly out_x0={120,0}, out_x1={80,0}.
